// File: rtl/s3g_rx.sv
// s3g_rx: receive-side framer for the S3G serial packet protocol.
// Hunts for the 0xD5 start byte, captures a length byte, up to MAX_LEN
// payload bytes and a trailing CRC8. It then presents a good packet on 16
// parallel byte outputs until the consumer acknowledges it.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rx_data, rx_valid byte stream from the UART receiver (one strobe per byte)
//   packet_ready      a good packet is held on payload_len/buf0..buf15
//   packet_ack        consumer took the packet; clears packet_ready
//   payload_len       length of the held packet
//   buf0..buf15       held payload bytes, zero at and beyond payload_len
//   busy              a packet is in progress
//   crc_err, len_err, timeout, overrun  one-cycle fault pulses
module s3g_rx #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       packet_ready,
  input  logic       packet_ack,
  output logic [7:0] payload_len,
  output logic [7:0] buf0,
  output logic [7:0] buf1,
  output logic [7:0] buf2,
  output logic [7:0] buf3,
  output logic [7:0] buf4,
  output logic [7:0] buf5,
  output logic [7:0] buf6,
  output logic [7:0] buf7,
  output logic [7:0] buf8,
  output logic [7:0] buf9,
  output logic [7:0] buf10,
  output logic [7:0] buf11,
  output logic [7:0] buf12,
  output logic [7:0] buf13,
  output logic [7:0] buf14,
  output logic [7:0] buf15,
  output logic       busy,
  output logic       crc_err,
  output logic       len_err,
  output logic       timeout,
  output logic       overrun
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_SYNC, S_LEN, S_DATA, S_CRC} state_t;

  state_t          state, state_n;
  logic [7:0]      work  [16];
  logic [7:0]      buf_r [16];
  logic [7:0]      len_r;
  logic [7:0]      crc_r;
  logic [4:0]      cnt;
  logic [TW-1:0]   tmo_cnt;

  logic            load_len, take_data, commit, crc_bad, len_bad, tmo_hit;

  // CRC-8, polynomial x^8+x^2+x+1, MSB first, same as the transmitter.
  function automatic logic [7:0] nextCRC8_D8(input logic [7:0] data,
                                             input logic [7:0] crc);
    logic [7:0] r;
    r = crc ^ data;
    for (int unsigned i = 0; i < 8; i++)
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_SYNC;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    load_len  = 1'b0;
    take_data = 1'b0;
    commit    = 1'b0;
    crc_bad   = 1'b0;
    len_bad   = 1'b0;
    // Expires on the idle cycle that would bring the count to TIMEOUT;
    // a byte arriving in that cycle wins.
    tmo_hit   = (state != S_SYNC) && !rx_valid && (tmo_cnt == TW'(TIMEOUT - 1));
    case (state)
      S_SYNC: if (rx_valid && rx_data == 8'hD5) state_n = S_LEN;
      S_LEN: if (rx_valid) begin
        if (rx_data > 8'(MAX_LEN)) begin
          len_bad = 1'b1;
          state_n = S_SYNC;
        end else begin
          load_len = 1'b1;
          state_n  = (rx_data == 8'd0) ? S_CRC : S_DATA;
        end
      end
      S_DATA: if (rx_valid) begin
        take_data = 1'b1;
        if ({3'b000, cnt} + 8'd1 == len_r) state_n = S_CRC;
      end
      S_CRC: if (rx_valid) begin
        state_n = S_SYNC;
        if (rx_data == crc_r) commit  = 1'b1;
        else                  crc_bad = 1'b1;
      end
      default: state_n = S_SYNC;
    endcase
    if (tmo_hit) state_n = S_SYNC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_r        <= '0;
      crc_r        <= '0;
      cnt          <= '0;
      tmo_cnt      <= '0;
      packet_ready <= 1'b0;
      payload_len  <= '0;
      crc_err      <= 1'b0;
      len_err      <= 1'b0;
      timeout      <= 1'b0;
      overrun      <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        work[i]  <= '0;
        buf_r[i] <= '0;
      end
    end else begin
      crc_err <= crc_bad;
      len_err <= len_bad;
      timeout <= tmo_hit;
      overrun <= commit && packet_ready && !packet_ack;

      if (rx_valid || state == S_SYNC) tmo_cnt <= '0;
      else                             tmo_cnt <= tmo_cnt + 1'b1;

      if (load_len) begin
        len_r <= rx_data;
        cnt   <= '0;
        crc_r <= '0;
        for (int unsigned i = 0; i < 16; i++) work[i] <= '0;
      end

      if (take_data) begin
        work[cnt[3:0]] <= rx_data;
        crc_r          <= nextCRC8_D8(rx_data, crc_r);
        cnt            <= cnt + 5'd1;
      end

      // Commit takes precedence over a same-cycle acknowledge.
      if (commit) begin
        packet_ready <= 1'b1;
        payload_len  <= len_r;
        for (int unsigned i = 0; i < 16; i++) buf_r[i] <= work[i];
      end else if (packet_ack) begin
        packet_ready <= 1'b0;
      end
    end
  end

  always_comb busy = (state != S_SYNC);

  assign buf0  = buf_r[0];
  assign buf1  = buf_r[1];
  assign buf2  = buf_r[2];
  assign buf3  = buf_r[3];
  assign buf4  = buf_r[4];
  assign buf5  = buf_r[5];
  assign buf6  = buf_r[6];
  assign buf7  = buf_r[7];
  assign buf8  = buf_r[8];
  assign buf9  = buf_r[9];
  assign buf10 = buf_r[10];
  assign buf11 = buf_r[11];
  assign buf12 = buf_r[12];
  assign buf13 = buf_r[13];
  assign buf14 = buf_r[14];
  assign buf15 = buf_r[15];

endmodule

// File: tb/tb_s3g_rx.sv
// Bench for s3g_rx: directed scenarios plus randomized packets checked
// against a packet-level reference model (held packet image and a
// bit-serial CRC over the payload message).
module tb_s3g_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       packet_ready;
  logic       packet_ack;
  logic [7:0] payload_len;
  logic [7:0] dut_buf [16];
  logic       busy, crc_err, len_err, timeout, overrun;

  int vectors    = 0;
  int miscompares = 0;

  // reference model of the held packet
  logic [7:0] exp_buf [16];
  logic [7:0] exp_len;
  logic       exp_ready;

  logic [7:0] pl [16];

  always #5 clk = ~clk;

  s3g_rx #(.MAX_LEN(16), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .packet_ready(packet_ready), .packet_ack(packet_ack),
    .payload_len(payload_len),
    .buf0(dut_buf[0]),   .buf1(dut_buf[1]),   .buf2(dut_buf[2]),   .buf3(dut_buf[3]),
    .buf4(dut_buf[4]),   .buf5(dut_buf[5]),   .buf6(dut_buf[6]),   .buf7(dut_buf[7]),
    .buf8(dut_buf[8]),   .buf9(dut_buf[9]),   .buf10(dut_buf[10]), .buf11(dut_buf[11]),
    .buf12(dut_buf[12]), .buf13(dut_buf[13]), .buf14(dut_buf[14]), .buf15(dut_buf[15]),
    .busy(busy), .crc_err(crc_err), .len_err(len_err),
    .timeout(timeout), .overrun(overrun)
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: observed no end of run, expected $finish");
    $fatal(1);
  end

  // CRC of the payload as polynomial division of the message bit stream
  // (x^8+x^2+x+1, MSB first, zero preset).
  function automatic logic [7:0] model_crc(input logic [7:0] p [16], input int n);
    logic [7:0] r;
    logic       fb;
    r = 8'h00;
    for (int i = 0; i < n; i++)
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ p[i][b];
        r  = {r[6:0], 1'b0};
        if (fb) r = r ^ 8'h07;
      end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ep = {crc_err, len_err, timeout, overrun}
  task automatic chk_pulses(input string tag, input logic [3:0] ep);
    chk({tag, ".crc_err"}, 32'(crc_err), 32'(ep[3]));
    chk({tag, ".len_err"}, 32'(len_err), 32'(ep[2]));
    chk({tag, ".timeout"}, 32'(timeout), 32'(ep[1]));
    chk({tag, ".overrun"}, 32'(overrun), 32'(ep[0]));
  endtask

  task automatic check_held(input string tag);
    chk({tag, ".packet_ready"}, 32'(packet_ready), 32'(exp_ready));
    chk({tag, ".payload_len"}, 32'(payload_len), 32'(exp_len));
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s.buf%0d", tag, i), 32'(dut_buf[i]), 32'(exp_buf[i]));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [3:0] ep);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = $urandom_range(255, 0);
    chk_pulses("byte", ep);
  endtask

  task automatic idle(input int n, input logic exp_busy);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_pulses("idle", 4'b0000);
      chk("idle.busy", 32'(busy), 32'(exp_busy));
    end
  endtask

  task automatic do_ack();
    packet_ack = 1'b1;
    tick();
    packet_ack = 1'b0;
    exp_ready  = 1'b0;
    chk("ack.packet_ready", 32'(packet_ready), 32'(1'b0));
    chk_pulses("ack", 4'b0000);
  endtask

  task automatic model_clear();
    exp_ready = 1'b0;
    exp_len   = 8'd0;
    for (int i = 0; i < 16; i++) exp_buf[i] = 8'd0;
  endtask

  task automatic send_pkt(input string tag, input int n, input logic [7:0] p [16],
                          input bit bad, input int mingap, input int maxgap,
                          input bit ack_crc);
    logic [7:0] c;
    logic [3:0] ep;
    c = model_crc(p, n) ^ (bad ? 8'h01 : 8'h00);
    send_byte(8'hD5, 4'b0000);
    chk({tag, ".busy_rise"}, 32'(busy), 32'(1'b1));
    idle($urandom_range(maxgap, mingap), 1'b1);
    send_byte(8'(n), 4'b0000);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(maxgap, mingap), 1'b1);
      send_byte(p[i], 4'b0000);
    end
    idle($urandom_range(maxgap, mingap), 1'b1);
    if (bad) ep = 4'b1000;
    else     ep = {3'b000, exp_ready && !ack_crc};
    packet_ack = ack_crc;
    send_byte(c, ep);
    packet_ack = 1'b0;
    if (!bad) begin
      exp_ready = 1'b1;
      exp_len   = 8'(n);
      for (int i = 0; i < 16; i++) exp_buf[i] = (i < n) ? p[i] : 8'd0;
    end else if (ack_crc) begin
      exp_ready = 1'b0;
    end
    chk({tag, ".busy_fall"}, 32'(busy), 32'(1'b0));
    check_held(tag);
    idle(1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; packet_ack = 1'b0;
    model_clear();
    tick(); tick();
    chk("reset.busy", 32'(busy), 32'(1'b0));
    chk_pulses("reset", 4'b0000);
    check_held("reset");
    rst = 1'b0;
    idle(2, 1'b0);

    // empty packet
    for (int i = 0; i < 16; i++) pl[i] = 8'h00;
    send_pkt("empty", 0, pl, 1'b0, 0, 0, 1'b0);
    do_ack();

    // full packet, back-to-back then with one-cycle gaps
    for (int i = 0; i < 16; i++) pl[i] = 8'(i);
    send_pkt("full", 16, pl, 1'b0, 0, 0, 1'b0);
    do_ack();
    send_pkt("full_gap", 16, pl, 1'b0, 1, 1, 1'b0);

    // bad CRC keeps previous outputs, then a good packet commits
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_pkt("badcrc", 3, pl, 1'b1, 0, 0, 1'b0);
    do_ack();
    send_pkt("after_bad", 3, pl, 1'b0, 0, 0, 1'b0);
    do_ack();

    // garbage and oversize length
    send_byte(8'h00, 4'b0000); chk("garb.busy", 32'(busy), 32'(1'b0));
    send_byte(8'hFF, 4'b0000); chk("garb.busy", 32'(busy), 32'(1'b0));
    send_byte(8'hD4, 4'b0000); chk("garb.busy", 32'(busy), 32'(1'b0));
    send_byte(8'hD5, 4'b0000);
    send_byte(8'h11, 4'b0100);
    chk("lenerr.busy", 32'(busy), 32'(1'b0));
    idle(1, 1'b0);
    pl[0] = 8'hAA;
    send_pkt("len1", 1, pl, 1'b0, 0, 0, 1'b0);
    do_ack();

    // D5 inside payload is ordinary data
    pl[0] = 8'hD5; pl[1] = 8'hD5;
    send_pkt("d5_data", 2, pl, 1'b0, 0, 0, 1'b0);

    // longest legal gap (19 idle cycles with TIMEOUT=20) does not abort
    pl[0] = 8'h5A; pl[1] = 8'hC3;
    send_pkt("gap19", 2, pl, 1'b0, 19, 19, 1'b0);

    // inter-byte timeout
    send_byte(8'hD5, 4'b0000);
    send_byte(8'h04, 4'b0000);
    send_byte(8'h01, 4'b0000);
    idle(19, 1'b1);
    tick();
    chk_pulses("timeout", 4'b0010);
    chk("timeout.busy", 32'(busy), 32'(1'b0));
    send_byte(8'h02, 4'b0000); chk("tmo_ign.busy", 32'(busy), 32'(1'b0));
    send_byte(8'h03, 4'b0000); chk("tmo_ign.busy", 32'(busy), 32'(1'b0));
    send_byte(8'h04, 4'b0000); chk("tmo_ign.busy", 32'(busy), 32'(1'b0));
    check_held("tmo_ign");
    do_ack();

    // overrun, then commit with same-cycle ack
    for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(255, 0));
    send_pkt("ovr_a", 5, pl, 1'b0, 0, 1, 1'b0);
    for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(255, 0));
    send_pkt("ovr_b", 7, pl, 1'b0, 0, 1, 1'b0);
    for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(255, 0));
    send_pkt("ack_crc", 4, pl, 1'b0, 0, 1, 1'b1);
    do_ack();

    // randomized packets
    for (int k = 0; k < 40; k++) begin
      int r, n, am;
      r = $urandom_range(9, 0);
      if (r == 0) begin
        send_byte(8'hD5, 4'b0000);
        send_byte(8'($urandom_range(255, 17)), 4'b0100);
        chk("rnd_len.busy", 32'(busy), 32'(1'b0));
        check_held("rnd_len");
      end else begin
        n = $urandom_range(16, 0);
        for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(255, 0));
        if (r == 2) pl[0] = 8'hD5;
        am = $urandom_range(2, 0);
        if (am == 1) do_ack();
        send_pkt("rnd", n, pl, r == 1, 0, 3, am == 2);
      end
    end

    // reset mid-payload
    send_byte(8'hD5, 4'b0000);
    send_byte(8'h05, 4'b0000);
    send_byte(8'h01, 4'b0000);
    send_byte(8'h02, 4'b0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    chk("midrst.busy", 32'(busy), 32'(1'b0));
    chk_pulses("midrst", 4'b0000);
    check_held("midrst");
    for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(255, 0));
    send_pkt("post_rst", 6, pl, 1'b0, 0, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
